// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, finds the start bit's falling edge and
// samples each data bit at its centre, then presents the byte with a one-clk done pulse.
module uart_rx #(
  parameter int freq      = 100_000_000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       done,
  output logic [7:0] rx_out
);

  localparam int CLKS_PER_BIT = freq / baud_rate + 1;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_done;
  logic [7:0]       r_rx_out;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_rx_d;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_clk_cnt_nxt;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_done_nxt;
  logic [7:0]       w_rx_out_nxt;

  assign done   = r_done;
  assign rx_out = r_rx_out;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; resets to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  // FSM state, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_done    <= 1'b0;
      r_rx_out  <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_done    <= w_done_nxt;
      r_rx_out  <= w_rx_out_nxt;
    end
  end

  // Next-state logic: counters are cleared (never wrapped) at every sample point.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_done_nxt    = 1'b0;
    w_rx_out_nxt  = r_rx_out;

    case (r_state)
      S_IDLE: begin
        // Only a 1->0 transition starts a frame; a line already low is ignored.
        if (r_rx_d && !r_rx_s) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = S_START;
        end else begin
          w_clk_cnt_nxt = '0;
        end
      end

      S_START: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_bit_idx_nxt = 3'd0;
            w_state_nxt   = S_DATA;
          end else begin
            w_state_nxt   = S_IDLE;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_nxt          = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_DONE;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        // Whole byte is published at once so rx_out is never seen half-assembled.
        w_rx_out_nxt = r_shift;
        w_done_nxt   = 1'b1;
        w_state_nxt  = S_IDLE;
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_clk_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1 MHz / 100 kbaud (11 clks per bit):
// a table of frames plus reset, glitch and mid-frame-reset sequences.
module tb_uart_rx;

  localparam int CPB = 11;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       done;
  logic [7:0] rx_out;

  int         n_cmp;
  int         n_err;
  int         done_cnt;
  int         dbl_cnt;
  logic       prev_done;
  logic [7:0] last_byte;

  typedef struct {
    logic [7:0] data;
    int         bit7_len;
    int         stop_len;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[11];

  uart_rx #(
    .freq      (1_000_000),
    .baud_rate (100_000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .done   (done),
    .rx_out (rx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts done pulses, remembers the byte shown with each, flags back-to-back highs.
  always @(negedge clk) begin
    prev_done <= done;
    if (done) begin
      done_cnt  <= done_cnt + 1;
      last_byte <= rx_out;
    end
    if (done && prev_done) begin
      dbl_cnt <= dbl_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bit7_len, input int stop_len);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 7; i++) drive_bit(b[i], CPB);
    drive_bit(b[7], CPB * bit7_len);
    drive_bit(1'b1, CPB * stop_len);
  endtask

  initial begin
    int         base;
    logic [7:0] hold;

    n_cmp     = 0;
    n_err     = 0;
    done_cnt  = 0;
    dbl_cnt   = 0;
    prev_done = 1'b0;
    last_byte = 8'h00;
    rx        = 1'b1;
    rst       = 1'b1;

    vecs[0]  = '{8'h00, 1, 1, 8'h00};
    vecs[1]  = '{8'hFF, 1, 1, 8'hFF};
    vecs[2]  = '{8'hA5, 1, 1, 8'hA5};
    vecs[3]  = '{8'h99, 1, 1, 8'h99};
    vecs[4]  = '{8'h99, 1, 1, 8'h99};
    vecs[5]  = '{8'h99, 1, 1, 8'h99};
    vecs[6]  = '{8'h99, 1, 1, 8'h99};
    vecs[7]  = '{8'h99, 1, 2, 8'h99};
    vecs[8]  = '{8'h01, 2, 1, 8'h01};
    vecs[9]  = '{8'h80, 1, 1, 8'h80};
    vecs[10] = '{8'h3C, 1, 1, 8'h3C};

    // Reset held while rx toggles: outputs must stay at reset values.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = i[0];
      @(negedge clk);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_rx_out", {24'd0, rx_out}, 32'h00);
    end
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("release_no_done", done_cnt, 0);

    // Table of frames, sent back-to-back with their stop bits as the only gap.
    for (int v = 0; v < 11; v++) begin
      base = done_cnt;
      send_frame(vecs[v].data, vecs[v].bit7_len, vecs[v].stop_len);
      check($sformatf("vec%0d_done_count", v), done_cnt - base, 1);
      check($sformatf("vec%0d_byte", v), {24'd0, last_byte}, {24'd0, vecs[v].exp_byte});
      check($sformatf("vec%0d_rx_out", v), {24'd0, rx_out}, {24'd0, vecs[v].exp_byte});
    end

    // Glitch shorter than half a bit: no frame, rx_out unchanged.
    repeat (20) @(negedge clk);
    base = done_cnt;
    hold = rx_out;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 3 * CPB * 10);
    check("glitch_no_done", done_cnt - base, 0);
    check("glitch_rx_out", {24'd0, rx_out}, {24'd0, hold});

    // Reset in the middle of data bit 4 of 8'h3C, held until the line is idle again.
    base = done_cnt;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(hold[i] ^ hold[i] ^ (8'h3C >> i) & 8'h01, CPB);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_rx_out", {24'd0, rx_out}, 32'h00);
    drive_bit(1'b1, CPB - CPB / 2 - 1);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    rst = 1'b0;
    repeat (3 * CPB * 10) @(negedge clk);
    check("midrst_no_done", done_cnt - base, 0);
    check("midrst_rx_out_after", {24'd0, rx_out}, 32'h00);
    send_frame(8'h5A, 1, 1);
    repeat (5) @(negedge clk);
    check("after_rst_done_count", done_cnt - base, 1);
    check("after_rst_byte", {24'd0, rx_out}, 32'h5A);

    // done must never stay high two clocks in a row.
    check("done_single_cycle", dbl_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
